// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Brief    : Program counter with LIFO call/return stack, zero-flag branches
//            and a single non-nesting level-sensitive interrupt.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module pc_unit #(
   parameter int unsigned     AW      = 10,
   parameter int unsigned     DEPTH   = 8,
   parameter logic [AW-1:0]   IRQ_VEC = AW'(1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic [2:0]                   op,
   input  logic [AW-1:0]                target,
   input  logic                         z,
   input  logic                         irq,
   output logic [AW-1:0]                pc,
   output logic [AW-1:0]                top,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         full,
   output logic                         empty,
   output logic                         err,
   output logic                         in_isr,
   output logic                         irq_ack
);

   localparam int unsigned LW = $clog2(DEPTH + 1);
   localparam int unsigned IW = $clog2(DEPTH);

   localparam logic [2:0] c_OP_NEXT = 3'b000;
   localparam logic [2:0] c_OP_JUMP = 3'b001;
   localparam logic [2:0] c_OP_JZ   = 3'b010;
   localparam logic [2:0] c_OP_JNZ  = 3'b011;
   localparam logic [2:0] c_OP_CALL = 3'b100;
   localparam logic [2:0] c_OP_RET  = 3'b101;
   localparam logic [2:0] c_OP_RETI = 3'b110;
   localparam logic [2:0] c_OP_HOLD = 3'b111;

   logic [AW-1:0] r_stack [DEPTH];
   logic [AW-1:0] r_pc;
   logic [LW-1:0] r_level;
   logic          r_err;
   logic          r_in_isr;
   logic          r_irq_ack;

   logic [AW-1:0] w_pc_nxt;
   logic [AW-1:0] w_pc_inc;
   logic [LW-1:0] w_level_nxt;
   logic          w_err_nxt;
   logic          w_isr_nxt;
   logic          w_ack_nxt;
   logic          w_push;
   logic [AW-1:0] w_push_data;
   logic [IW-1:0] w_push_idx;
   logic [IW-1:0] w_top_idx;
   logic          w_full;
   logic          w_empty;
   logic          w_take_irq;

   assign w_full     = (r_level == LW'(DEPTH));
   assign w_empty    = (r_level == '0);
   assign w_pc_inc   = r_pc + AW'(1);
   assign w_top_idx  = IW'(r_level - LW'(1));
   assign w_push_idx = IW'(r_level);
   // A full stack blocks the interrupt silently; it is retried while irq stays high.
   assign w_take_irq = en && irq && !r_in_isr && !w_full;

   always_comb begin
      w_pc_nxt    = r_pc;
      w_level_nxt = r_level;
      w_err_nxt   = r_err;
      w_isr_nxt   = r_in_isr;
      w_ack_nxt   = 1'b0;
      w_push      = 1'b0;
      w_push_data = '0;
      if (w_take_irq) begin
         w_push      = 1'b1;
         w_push_data = r_pc;
         w_level_nxt = r_level + LW'(1);
         w_pc_nxt    = IRQ_VEC;
         w_isr_nxt   = 1'b1;
         w_ack_nxt   = 1'b1;
      end else if (en) begin
         case (op)
            c_OP_NEXT: w_pc_nxt = w_pc_inc;
            c_OP_JUMP: w_pc_nxt = target;
            c_OP_JZ:   w_pc_nxt = z  ? target : w_pc_inc;
            c_OP_JNZ:  w_pc_nxt = !z ? target : w_pc_inc;
            c_OP_CALL: begin
               if (w_full) begin
                  w_pc_nxt  = w_pc_inc;
                  w_err_nxt = 1'b1;
               end else begin
                  w_push      = 1'b1;
                  w_push_data = w_pc_inc;
                  w_level_nxt = r_level + LW'(1);
                  w_pc_nxt    = target;
               end
            end
            c_OP_RET, c_OP_RETI: begin
               if (w_empty) begin
                  w_pc_nxt  = w_pc_inc;
                  w_err_nxt = 1'b1;
               end else begin
                  w_pc_nxt    = top;
                  w_level_nxt = r_level - LW'(1);
               end
               if (op == c_OP_RETI) w_isr_nxt = 1'b0;
            end
            c_OP_HOLD: w_pc_nxt = r_pc;
            default:   w_pc_nxt = r_pc;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc      <= '0;
         r_level   <= '0;
         r_err     <= 1'b0;
         r_in_isr  <= 1'b0;
         r_irq_ack <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) r_stack[i] <= '0;
      end else begin
         r_pc      <= w_pc_nxt;
         r_level   <= w_level_nxt;
         r_err     <= w_err_nxt;
         r_in_isr  <= w_isr_nxt;
         r_irq_ack <= w_ack_nxt;
         if (w_push) r_stack[w_push_idx] <= w_push_data;
      end
   end

   assign pc      = r_pc;
   assign level   = r_level;
   assign full    = w_full;
   assign empty   = w_empty;
   assign err     = r_err;
   assign in_isr  = r_in_isr;
   assign irq_ack = r_irq_ack;
   assign top     = w_empty ? '0 : r_stack[w_top_idx];

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Brief    : Directed self-checking bench for pc_unit (AW=10, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

   localparam logic [2:0] NEXT = 3'b000, JUMP = 3'b001, JZ = 3'b010, JNZ = 3'b011;
   localparam logic [2:0] CALL = 3'b100, RET = 3'b101, RETI = 3'b110, HOLD = 3'b111;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b1;
   logic [2:0] op = HOLD;
   logic [9:0] target = '0;
   logic       z = 1'b0;
   logic       irq = 1'b0;
   logic [9:0] pc, top;
   logic [2:0] level;
   logic       full, empty, err, in_isr, irq_ack;

   int n_chk = 0;
   int n_pass = 0;

   pc_unit #(.AW(10), .DEPTH(4), .IRQ_VEC(10'h3F0)) dut (
      .clk(clk), .reset(reset), .en(en), .op(op), .target(target), .z(z), .irq(irq),
      .pc(pc), .top(top), .level(level), .full(full), .empty(empty), .err(err),
      .in_isr(in_isr), .irq_ack(irq_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic step(input logic [2:0] o, input logic [9:0] t);
      op = o; target = t;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      en = 1'b1; irq = 1'b0; z = 1'b0; op = HOLD; target = '0;
      reset = 1'b0;
      #3;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      reset = 1'b0; #1;
      n_chk++; if (pc !== 10'h000) $display("FAIL rst_pc got=%h exp=000", pc); else n_pass++;
      n_chk++; if (level !== 3'd0 || empty !== 1'b1 || full !== 1'b0) $display("FAIL rst_level got=%0d/%b/%b exp=0/1/0", level, empty, full); else n_pass++;
      n_chk++; if (err !== 1'b0 || in_isr !== 1'b0 || irq_ack !== 1'b0 || top !== 10'h0) $display("FAIL rst_flags got=%b%b%b top=%h exp=000 top=000", err, in_isr, irq_ack, top); else n_pass++;
      @(negedge clk); reset = 1'b1;
      step(NEXT, 10'h0);
      n_chk++; if (pc !== 10'h001) $display("FAIL next1 got=%h exp=001", pc); else n_pass++;
      step(NEXT, 10'h0);
      n_chk++; if (pc !== 10'h002) $display("FAIL next2 got=%h exp=002", pc); else n_pass++;
      step(NEXT, 10'h0);
      n_chk++; if (pc !== 10'h003 || empty !== 1'b1 || err !== 1'b0) $display("FAIL next3 got=%h e=%b err=%b exp=003 1 0", pc, empty, err); else n_pass++;
      #2 reset = 1'b0; #1;
      n_chk++; if (pc !== 10'h000) $display("FAIL async_rst got=%h exp=000", pc); else n_pass++;
   endtask

   task automatic test_call_ret();
      do_reset();
      step(JUMP, 10'h005);
      step(CALL, 10'h100);
      n_chk++; if (pc !== 10'h100 || top !== 10'h006 || level !== 3'd1) $display("FAIL call pc=%h top=%h lvl=%0d exp=100 006 1", pc, top, level); else n_pass++;
      step(RET, 10'h000);
      n_chk++; if (pc !== 10'h006 || level !== 3'd0 || empty !== 1'b1) $display("FAIL ret pc=%h lvl=%0d e=%b exp=006 0 1", pc, level, empty); else n_pass++;
   endtask

   task automatic test_overflow();
      do_reset();
      step(JUMP, 10'h010);
      step(CALL, 10'h020);
      step(CALL, 10'h030);
      step(CALL, 10'h040);
      step(CALL, 10'h050);
      n_chk++; if (level !== 3'd4 || full !== 1'b1 || top !== 10'h041 || err !== 1'b0) $display("FAIL ovf_fill lvl=%0d f=%b top=%h err=%b exp=4 1 041 0", level, full, top, err); else n_pass++;
      step(CALL, 10'h060);
      n_chk++; if (pc !== 10'h051 || err !== 1'b1 || level !== 3'd4 || top !== 10'h041) $display("FAIL ovf_call pc=%h err=%b lvl=%0d top=%h exp=051 1 4 041", pc, err, level, top); else n_pass++;
      step(RET, 10'h0);
      n_chk++; if (pc !== 10'h041 || level !== 3'd3 || err !== 1'b1 || top !== 10'h031) $display("FAIL ovf_ret pc=%h lvl=%0d err=%b top=%h exp=041 3 1 031", pc, level, err, top); else n_pass++;
      step(RET, 10'h0);
      n_chk++; if (pc !== 10'h031 || err !== 1'b1) $display("FAIL ovf_sticky pc=%h err=%b exp=031 1", pc, err); else n_pass++;
   endtask

   task automatic test_underflow_wrap();
      do_reset();
      step(JUMP, 10'h020);
      step(RET, 10'h0);
      n_chk++; if (pc !== 10'h021 || err !== 1'b1 || level !== 3'd0 || top !== 10'h0) $display("FAIL unf pc=%h err=%b lvl=%0d top=%h exp=021 1 0 000", pc, err, level, top); else n_pass++;
      step(JUMP, 10'h3FF);
      step(NEXT, 10'h0);
      n_chk++; if (pc !== 10'h000) $display("FAIL wrap pc=%h exp=000", pc); else n_pass++;
   endtask

   task automatic test_branch_stall();
      do_reset();
      z = 1'b1;
      step(JZ, 10'h040);
      n_chk++; if (pc !== 10'h040) $display("FAIL jz_taken pc=%h exp=040", pc); else n_pass++;
      step(JNZ, 10'h040);
      n_chk++; if (pc !== 10'h041) $display("FAIL jnz_not pc=%h exp=041", pc); else n_pass++;
      z = 1'b0;
      step(JNZ, 10'h080);
      n_chk++; if (pc !== 10'h080) $display("FAIL jnz_taken pc=%h exp=080", pc); else n_pass++;
      step(JZ, 10'h040);
      n_chk++; if (pc !== 10'h081) $display("FAIL jz_not pc=%h exp=081", pc); else n_pass++;
      en = 1'b0; irq = 1'b1;
      step(CALL, 10'h200);
      step(JUMP, 10'h200);
      n_chk++; if (pc !== 10'h081 || level !== 3'd0 || in_isr !== 1'b0 || irq_ack !== 1'b0) $display("FAIL stall pc=%h lvl=%0d isr=%b ack=%b exp=081 0 0 0", pc, level, in_isr, irq_ack); else n_pass++;
      en = 1'b1; irq = 1'b0;
      step(HOLD, 10'h200);
      n_chk++; if (pc !== 10'h081 || level !== 3'd0) $display("FAIL hold pc=%h lvl=%0d exp=081 0", pc, level); else n_pass++;
   endtask

   task automatic test_irq();
      do_reset();
      step(JUMP, 10'h030);
      irq = 1'b1;
      step(JUMP, 10'h123);
      n_chk++; if (pc !== 10'h3F0 || top !== 10'h030 || in_isr !== 1'b1 || irq_ack !== 1'b1 || level !== 3'd1) $display("FAIL irq_take pc=%h top=%h isr=%b ack=%b lvl=%0d exp=3f0 030 1 1 1", pc, top, in_isr, irq_ack, level); else n_pass++;
      step(NEXT, 10'h0);
      n_chk++; if (pc !== 10'h3F1 || irq_ack !== 1'b0 || level !== 3'd1) $display("FAIL irq_nonest pc=%h ack=%b lvl=%0d exp=3f1 0 1", pc, irq_ack, level); else n_pass++;
      step(RETI, 10'h0);
      n_chk++; if (pc !== 10'h030 || in_isr !== 1'b0 || level !== 3'd0 || irq_ack !== 1'b0) $display("FAIL reti pc=%h isr=%b lvl=%0d ack=%b exp=030 0 0 0", pc, in_isr, level, irq_ack); else n_pass++;
      step(NEXT, 10'h0);
      n_chk++; if (pc !== 10'h3F0 || irq_ack !== 1'b1 || top !== 10'h030) $display("FAIL retake pc=%h ack=%b top=%h exp=3f0 1 030", pc, irq_ack, top); else n_pass++;
      irq = 1'b0;
      step(RETI, 10'h0);
      step(CALL, 10'h100);
      step(CALL, 10'h200);
      step(CALL, 10'h300);
      step(CALL, 10'h050);
      irq = 1'b1;
      step(NEXT, 10'h0);
      n_chk++; if (pc !== 10'h051 || in_isr !== 1'b0 || err !== 1'b0 || irq_ack !== 1'b0 || level !== 3'd4) $display("FAIL irq_full pc=%h isr=%b err=%b ack=%b lvl=%0d exp=051 0 0 0 4", pc, in_isr, err, irq_ack, level); else n_pass++;
      irq = 1'b0;
   endtask

   task automatic test_reti_underflow();
      do_reset();
      irq = 1'b1;
      step(NEXT, 10'h0);
      irq = 1'b0;
      step(RET, 10'h0);
      n_chk++; if (pc !== 10'h000 || in_isr !== 1'b1 || level !== 3'd0) $display("FAIL ret_in_isr pc=%h isr=%b lvl=%0d exp=000 1 0", pc, in_isr, level); else n_pass++;
      step(RETI, 10'h0);
      n_chk++; if (pc !== 10'h001 || in_isr !== 1'b0 || err !== 1'b1 || level !== 3'd0) $display("FAIL reti_unf pc=%h isr=%b err=%b lvl=%0d exp=001 0 1 0", pc, in_isr, err, level); else n_pass++;
      step(CALL, 10'h200);
      #2 reset = 1'b0; #1;
      n_chk++; if (pc !== 10'h000 || level !== 3'd0 || err !== 1'b0 || top !== 10'h0) $display("FAIL rst_midcall pc=%h lvl=%0d err=%b top=%h exp=000 0 0 000", pc, level, err, top); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_call_ret();
      test_overflow();
      test_underflow_wrap();
      test_branch_stall();
      test_irq();
      test_reti_underflow();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Parametrised program-sequencing unit for the single-cycle CPU: program counter, call/return stack and a single level-sensitive interrupt. It is the successor to the fixed 10-bit PC plus stack in the current datapath. It adds configurable address width and stack depth, conditional jumps on the zero flag, overflow/underflow detection, and interrupt vectoring with return. It drives the program-memory address and receives the decoded sequencing op from the control unit.

## Interface

- AW, 10, program address width in bits
- DEPTH, 8, call-stack entries (≥2)
- IRQ_VEC, 1, interrupt vector address (AW bits)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  advance enable; 0 = stall, all state held
- op  in  3  sequencing op (encoding below)
- target  in  AW  jump/call target from instruction field
- z  in  1  zero flag from the flag flip-flop
- irq  in  1  interrupt request, level-sensitive
- pc  out  AW  current program address (registered)
- top  out  AW  stack top entry; 0 when empty
- level  out  $clog2(DEPTH+1)  number of occupied entries
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- err  out  1  sticky overflow/underflow flag; cleared only by reset
- in_isr  out  1  interrupt handler active
- irq_ack  out  1  one-cycle pulse when interrupt taken

## Operation

- op encoding: 000 NEXT, 001 JUMP, 010 JZ, 011 JNZ, 100 CALL, 101 RET, 110 RETI, 111 HOLD.
- NEXT: pc ← pc+1, modulo 2^AW (wraps to 0).
- JUMP: pc ← target.
- JZ: pc ← target if z=1, else pc+1. JNZ: pc ← target if z=0, else pc+1.
- CALL, not full: push pc+1 (wrapped); pc ← target.
- CALL, full: no push, no jump; pc ← pc+1; err ← 1.
- RET, not empty: pc ← top; pop.
- RET, empty: pc ← pc+1; err ← 1; level stays 0.
- RETI: same as RET; additionally in_isr ← 0, including on underflow.
- HOLD: pc unchanged; stack unchanged.
- Interrupt condition: en=1, irq=1, in_isr=0 and not full.
  - Overrides op entirely. The instruction at pc is not executed.
  - Push pc (unincremented); pc ← IRQ_VEC; in_isr ← 1; irq_ack ← 1 for one cycle.
- irq while full: not taken, no err. op executes normally. The interrupt is retried each cycle while irq is held.
- irq while in_isr=1: ignored; no nesting.
- en=0: pc, stack, level, err and in_isr hold. irq_ack ← 0. irq is ignored.
- Stack is LIFO. top is combinational from the storage entry at level-1.
- Reset (reset=0, asynchronous):
  - pc=0, level=0, err=0, in_isr=0, irq_ack=0, all stack entries 0.
  - Asserting reset mid-call or mid-ISR discards all state immediately.

## Timing

- All state updates on the rising clk edge. The next state is computed combinationally from op, target, z, irq and en in the same cycle (single-cycle CPU: zero-latency decision).
- pc, level, err, in_isr and irq_ack are registers, valid after the edge. full, empty and top are combinational from registers, with no dependence on inputs.
- Stall: op must be held by the control unit while en=0.
- Return address pushed by CALL is visible on top in the cycle after the CALL edge.
- irq_ack is high exactly in the cycle whose pc equals IRQ_VEC after the take.
- Reset release is synchronised by the system. The first advance is on the first edge with reset=1.

## Test plan

All scenarios use AW=10, DEPTH=4, IRQ_VEC=10'h3F0.

- Reset, then 3× NEXT → pc 1, 2, 3; empty=1, err=0. Assert reset mid-run → pc=0 immediately, without a clock edge.
- At pc=5, CALL target=0x100 → pc=0x100, top=6, level=1. Then RET → pc=6, level=0, empty=1.
- Five nested CALLs from pc=0x10 → level saturates at 4, full=1. The fifth call leaves pc at its pc+1 and sets err=1. err stays 1 through subsequent RETs until reset.
- RET with empty stack at pc=0x20 → pc=0x21, err=1, level=0. pc=0x3FF with NEXT → pc=0.
- z=1 with JZ target=0x40 → pc=0x40. z=1 with JNZ target=0x40 at pc=0x40 → pc=0x41. en=0 with any op → pc unchanged.
- Interrupt sequence:
  - At pc=0x30, op=JUMP, raise irq → pc=0x3F0, top=0x30, in_isr=1, irq_ack one cycle.
  - irq held → no second take.
  - RETI → pc=0x30, in_isr=0. The interrupt retakes next cycle if irq is still 1.
  - With stack full, irq is not taken and err stays 0.
